// File: rtl/apb_cmd_queue_if.sv
// Signal bundle for apb_cmd_queue: request intake, APB master command/completion,
// response delivery, occupancy and FSM state visibility.
interface apb_cmd_queue_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    // req_* and rsp_* are valid/ready channels: a beat moves on a rising edge where
    // valid and ready are both high; payload must stay stable while valid waits.
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  req_write;
    logic [DATA_WIDTH-1:0] req_wdata;

    logic [ADDR_WIDTH-1:0] BADDR;
    logic                  BWRITE;
    logic [DATA_WIDTH-1:0] BWDATA;
    logic                  start_transfer;
    logic                  BDONE;
    logic [DATA_WIDTH-1:0] BRDATA;
    logic                  BERR;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    logic [CW-1:0]         count;
    logic [1:0]            dbg_state;

    modport slave (
        input  req_valid, req_addr, req_write, req_wdata,
        input  BDONE, BRDATA, BERR, rsp_ready,
        output req_ready, BADDR, BWRITE, BWDATA, start_transfer,
        output rsp_valid, rsp_rdata, rsp_err, count, dbg_state
    );

    modport master (
        output req_valid, req_addr, req_write, req_wdata,
        output BDONE, BRDATA, BERR, rsp_ready,
        input  req_ready, BADDR, BWRITE, BWDATA, start_transfer,
        input  rsp_valid, rsp_rdata, rsp_err, count, dbg_state
    );
endinterface

// File: rtl/apb_cmd_queue.sv
// Circular command FIFO feeding an APB master one transfer at a time, with a
// WAIT-phase timeout that forces an error completion.
module apb_cmd_queue #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int TIMEOUT    = 16
) (
    input logic              PCLK,
    input logic              PRESET,
    apb_cmd_queue_if.slave   bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t                r_state;
    state_t                w_next_state;

    logic [ADDR_WIDTH-1:0] r_mem_addr  [DEPTH];
    logic                  r_mem_write [DEPTH];
    logic [DATA_WIDTH-1:0] r_mem_wdata [DEPTH];

    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic [TW-1:0]         r_tmo;
    logic                  r_start;
    logic [ADDR_WIDTH-1:0] r_baddr;
    logic                  r_bwrite;
    logic [DATA_WIDTH-1:0] r_bwdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_err;

    logic                  w_ready;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_issue;
    logic                  w_done;
    logic                  w_tmo_fire;

    // Ready depends only on registered occupancy, so a full queue refuses a push
    // even in the cycle it pops.
    assign w_ready = (r_count != CW'(DEPTH));
    assign w_push  = bus.req_valid && w_ready;
    assign w_pop   = w_done || w_tmo_fire;

    always_comb begin
        w_next_state = r_state;
        w_issue      = 1'b0;
        w_done       = 1'b0;
        w_tmo_fire   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0) begin
                    w_next_state = S_ISSUE;
                    w_issue      = 1'b1;
                end
            end
            S_ISSUE: w_next_state = S_WAIT;
            S_WAIT: begin
                if (bus.BDONE) begin
                    w_done       = 1'b1;
                    w_next_state = S_RESP;
                end else if (r_tmo == TW'(TIMEOUT - 1)) begin
                    w_tmo_fire   = 1'b1;
                    w_next_state = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge PCLK) begin
        if (w_push) begin
            r_mem_addr[r_wr_ptr]  <= bus.req_addr;
            r_mem_write[r_wr_ptr] <= bus.req_write;
            r_mem_wdata[r_wr_ptr] <= bus.req_wdata;
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_tmo    <= '0;
            r_start  <= 1'b0;
            r_baddr  <= '0;
            r_bwrite <= 1'b0;
            r_bwdata <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            // Counter restarts whenever WAIT is entered or left.
            if ((r_state == S_WAIT) && (w_next_state == S_WAIT)) begin
                r_tmo <= r_tmo + 1'b1;
            end else begin
                r_tmo <= '0;
            end

            r_start <= w_issue;
            if (w_issue) begin
                r_baddr  <= r_mem_addr[r_rd_ptr];
                r_bwrite <= r_mem_write[r_rd_ptr];
                r_bwdata <= r_mem_wdata[r_rd_ptr];
            end

            if (w_done) begin
                r_rdata <= r_bwrite ? '0 : bus.BRDATA;
                r_err   <= bus.BERR;
            end else if (w_tmo_fire) begin
                r_rdata <= '0;
                r_err   <= 1'b1;
            end
        end
    end

    assign bus.req_ready      = w_ready;
    assign bus.start_transfer = r_start;
    assign bus.BADDR          = r_baddr;
    assign bus.BWRITE         = r_bwrite;
    assign bus.BWDATA         = r_bwdata;
    assign bus.rsp_valid      = (r_state == S_RESP);
    assign bus.rsp_rdata      = r_rdata;
    assign bus.rsp_err        = r_err;
    assign bus.count          = r_count;
    assign bus.dbg_state      = r_state;
endmodule

// File: tb/tb_apb_cmd_queue.sv
// Directed bench for apb_cmd_queue: issued commands and responses are predicted
// into expected queues when stimulus is driven and compared as the DUT produces them.
module tb_apb_cmd_queue;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;

    logic PCLK   = 1'b0;
    logic PRESET = 1'b0;

    always #5 PCLK = ~PCLK;

    apb_cmd_queue_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

    apb_cmd_queue #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .PCLK  (PCLK),
        .PRESET(PRESET),
        .bus   (bus)
    );

    logic [AW+DW:0] iss_q[$];
    logic [DW:0]    rsp_q[$];
    logic [AW+DW:0] last_issued;
    int n_checks = 0;
    int n_pass   = 0;
    int pending_issues = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    endtask

    // Every clock step also scoreboards any start_transfer pulse.
    task automatic tick();
        logic [AW+DW:0] e;
        @(posedge PCLK);
        #1;
        if (bus.start_transfer === 1'b1) begin
            if (iss_q.size() == 0) begin
                check("unexpected_issue", 1, 0);
            end else begin
                e = iss_q.pop_front();
                last_issued = {bus.BADDR, bus.BWRITE, bus.BWDATA};
                check("issue_cmd", last_issued, e);
                pending_issues++;
            end
        end
    endtask

    task automatic push(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d);
        check("push_ready", bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        bus.req_write = w;
        bus.req_wdata = d;
        iss_q.push_back({a, w, d});
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_issue(output int n);
        n = 0;
        while (pending_issues == 0 && n < 40) begin
            tick();
            n++;
        end
        check("issue_seen", (pending_issues > 0), 1);
        if (pending_issues > 0) pending_issues--;
    endtask

    task automatic bdone(input int delay, input logic [DW-1:0] rd, input logic err, input logic w);
        repeat (delay) tick();
        check("cmd_hold", {bus.BADDR, bus.BWRITE, bus.BWDATA}, last_issued);
        bus.BDONE  = 1'b1;
        bus.BRDATA = rd;
        bus.BERR   = err;
        rsp_q.push_back({(w ? {DW{1'b0}} : rd), err});
        tick();
        bus.BDONE  = 1'b0;
        bus.BRDATA = '0;
        bus.BERR   = 1'b0;
    endtask

    task automatic get_resp();
        int n;
        logic [DW:0] e;
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check("rsp_seen", bus.rsp_valid, 1);
        if (rsp_q.size() > 0) begin
            e = rsp_q.pop_front();
            check("rsp_data", {bus.rsp_rdata, bus.rsp_err}, e);
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        check("rsp_drop", bus.rsp_valid, 0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_count"}, bus.count, 0);
        check({tag, "_req_ready"}, bus.req_ready, 1);
        check({tag, "_start"}, bus.start_transfer, 0);
        check({tag, "_baddr"}, bus.BADDR, 0);
        check({tag, "_bwrite"}, bus.BWRITE, 0);
        check({tag, "_bwdata"}, bus.BWDATA, 0);
        check({tag, "_rsp_valid"}, bus.rsp_valid, 0);
        check({tag, "_rsp_rdata"}, bus.rsp_rdata, 0);
        check({tag, "_rsp_err"}, bus.rsp_err, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        logic [DW:0] e;
        logic seen;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_write = 1'b0;
        bus.req_wdata = '0;
        bus.BDONE     = 1'b0;
        bus.BRDATA    = '0;
        bus.BERR      = 1'b0;
        bus.rsp_ready = 1'b0;

        // Reset applied before the first clock edge must act asynchronously.
        #2 PRESET = 1'b1;
        #1 check_reset_values("reset");
        tick();
        tick();
        PRESET = 1'b0;

        // Single read with latency check.
        push(32'h10, 1'b0, 32'h0);
        wait_issue(n);
        check("issue_latency", n, 1);
        bdone(2, 32'hCAFEF00D, 1'b0, 1'b0);
        get_resp();

        // Fill to full with BDONE low, then drain and wrap the pointers.
        push(32'h100, 1'b0, 32'h0);
        push(32'h104, 1'b1, 32'hA1);
        push(32'h108, 1'b0, 32'h0);
        push(32'h10C, 1'b1, 32'hA3);
        check("full_count", bus.count, 4);
        check("full_ready", bus.req_ready, 0);
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'hDEAD;
        tick();
        bus.req_valid = 1'b0;
        check("stall_count", bus.count, 4);
        for (int i = 0; i < 4; i++) begin
            wait_issue(n);
            bdone(1, 32'h5000 + i, 1'b0, (i % 2) == 1);
            get_resp();
        end
        check("drained_count", bus.count, 0);
        push(32'h200, 1'b0, 32'h0);
        push(32'h204, 1'b1, 32'hB1);
        for (int i = 0; i < 2; i++) begin
            wait_issue(n);
            bdone(1, 32'h6000 + i, 1'b0, i == 1);
            get_resp();
        end

        // Write with slave error: read data must be masked.
        push(32'h20, 1'b1, 32'h55AA55AA);
        wait_issue(n);
        bdone(2, 32'h1234, 1'b1, 1'b1);
        get_resp();

        // Timeout: 16 WAIT cycles, then error response; second entry follows.
        push(32'h30, 1'b0, 32'h0);
        push(32'h40, 1'b0, 32'h0);
        wait_issue(n);
        rsp_q.push_back({{DW{1'b0}}, 1'b1});
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check("timeout_cycles", n, TIMEOUT + 1);
        check("timeout_count", bus.count, 1);
        get_resp();
        wait_issue(n);
        bdone(2, 32'h7777, 1'b0, 1'b0);
        get_resp();

        // Response backpressure with spurious BDONE pulses.
        push(32'h50, 1'b0, 32'h0);
        wait_issue(n);
        bdone(2, 32'hA5A5A5A5, 1'b0, 1'b0);
        e = rsp_q[0];
        for (int i = 0; i < 5; i++) begin
            bus.BDONE  = 1'b1;
            bus.BRDATA = 32'h0BAD0BAD;
            bus.BERR   = 1'b1;
            tick();
            check("bp_valid", bus.rsp_valid, 1);
            check("bp_data", {bus.rsp_rdata, bus.rsp_err}, e);
        end
        bus.BDONE  = 1'b0;
        bus.BRDATA = '0;
        bus.BERR   = 1'b0;
        check("bp_count", bus.count, 0);
        get_resp();

        // Reset while a write is in WAIT with three entries queued.
        push(32'h60, 1'b1, 32'h11);
        push(32'h70, 1'b0, 32'h0);
        push(32'h80, 1'b0, 32'h0);
        wait_issue(n);
        tick();
        check("pre_reset_count", bus.count, 3);
        PRESET = 1'b1;
        #1 check_reset_values("midreset");
        iss_q.delete();
        rsp_q.delete();
        pending_issues = 0;
        tick();
        tick();
        PRESET = 1'b0;
        seen = 1'b0;
        repeat (25) begin
            tick();
            if (bus.rsp_valid === 1'b1) seen = 1'b1;
        end
        check("no_rsp_after_reset", seen, 0);
        check("post_reset_count", bus.count, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/apb_cmd_queue.md
APB_CMD_QUEUE -- requirements
Module: apb_cmd_queue

Interface
REQ-001 Parameters, one per line: ADDR_WIDTH, 32, address width; DATA_WIDTH, 32, data width; DEPTH, 4, queue entries (power of two, >=2); TIMEOUT, 16, max WAIT cycles before forced error completion.
REQ-002 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-003 Ports: PCLK  in  1  clock, all state updates on the rising edge.
REQ-004 PRESET  in  1  asynchronous active-high reset.
REQ-005 req_valid  in  1  request offered; req_ready  out  1  queue can accept.
REQ-006 req_addr  in  ADDR_WIDTH; req_write  in  1 (1=write); req_wdata  in  DATA_WIDTH: request payload.
REQ-007 BADDR  out  ADDR_WIDTH; BWRITE  out  1; BWDATA  out  DATA_WIDTH: command to the downstream APB master.
REQ-008 start_transfer  out  1  one-cycle pulse launching a master transfer.
REQ-009 BDONE  in  1  one-cycle pulse from the master when the access phase completes; BRDATA  in  DATA_WIDTH and BERR  in  1 are valid in that cycle.
REQ-010 rsp_valid  out  1; rsp_ready  in  1; rsp_rdata  out  DATA_WIDTH; rsp_err  out  1: completion response.
REQ-011 count  out  $clog2(DEPTH)+1  current occupancy.

Function
REQ-012 The queue SHALL be a circular FIFO of DEPTH entries {addr, write, wdata}, with write/read pointers wrapping from DEPTH-1 to 0.
REQ-013 req_ready SHALL equal (count != DEPTH), combinationally from registered count; push occurs when req_valid && req_ready.
REQ-014 With a full queue, a push SHALL NOT be accepted even in a pop cycle; a simultaneous push and pop on a non-full queue SHALL leave count unchanged.
REQ-015 FSM states: IDLE, ISSUE, WAIT, RESP.
REQ-016 IDLE->ISSUE when count>0 at the clock edge; otherwise stay in IDLE.
REQ-017 In ISSUE (exactly one cycle), start_transfer=1 and BADDR/BWRITE/BWDATA SHALL equal the head entry, with all of them registered; then go to WAIT.
REQ-018 BADDR/BWRITE/BWDATA SHALL hold stable from ISSUE through the cycle BDONE is sampled or the timeout fires.
REQ-019 In WAIT, BDONE=1 SHALL pop the head, capture rsp_rdata = BWRITE ? 0 : BRDATA and rsp_err = BERR, and move to RESP.
REQ-020 A WAIT cycle counter SHALL reset on entering WAIT; if it reaches TIMEOUT-1 with BDONE=0, the block SHALL pop the head, set rsp_rdata=0 and rsp_err=1, and move to RESP. If BDONE and the timeout coincide, BDONE SHALL win.
REQ-021 In RESP, rsp_valid=1 with rsp_rdata/rsp_err stable; on rsp_ready=1, go to IDLE and drop rsp_valid the next cycle.
REQ-022 BDONE SHALL be ignored in IDLE, ISSUE and RESP.
REQ-023 Latency: a push accepted at edge k into an empty idle queue SHALL produce start_transfer=1 between edges k+1 and k+2.
REQ-024 Only one transfer SHALL be outstanding at a time; requests SHALL be issued and answered strictly in FIFO order.

Reset
REQ-025 On PRESET=1, immediately and independent of PCLK: state=IDLE, pointers=0, count=0, start_transfer=0, BADDR=0, BWRITE=0, BWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, timeout counter=0, req_ready=1.
REQ-026 Reset mid-transfer SHALL discard all queued entries and any in-flight transfer, with no response produced.
REQ-027 Queue storage contents need not be reset.

Verification
REQ-028 Single read: push {addr=0x10, write=0} into an idle queue; BDONE two cycles after start_transfer with BRDATA=0xCAFEF00D, BERR=0 -> one start_transfer pulse with BADDR=0x10, then rsp_valid=1 with rsp_rdata=0xCAFEF00D, rsp_err=0.
REQ-029 Fill/wrap: with BDONE held low, push 4 requests -> count=4, req_ready=0, fifth request stalls; complete all 4, then push 2 more -> issue order matches push order across pointer wrap.
REQ-030 Write with slave error: push {0x20, write=1, 0x55AA55AA}; BDONE with BERR=1 and BRDATA=0x1234 -> BWDATA=0x55AA55AA, response rsp_rdata=0, rsp_err=1.
REQ-031 Timeout: push a read and never assert BDONE -> after 16 WAIT cycles the response has rsp_err=1, rsp_rdata=0, count decremented, and the next entry is issued after rsp_ready.
REQ-032 Backpressure and reset: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and its data stay stable and spurious BDONE pulses are ignored; then assert PRESET mid-WAIT with 3 entries queued -> all outputs take reset values asynchronously, count=0, and no response appears after release.
